// File: rtl/pkg_dtypes.sv
// Shared defaults and default-width transaction types for the execution-unit receive buffer.
package pkg_dtypes;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IDX_BITS   = 3;
  localparam int DEF_TAG_BITS   = 4;
  localparam int DEF_NUM_WR     = 2;
  localparam int DEF_NUM_RD     = 2;
  localparam int DEF_BYPASS_EN  = 1;
  localparam int DEF_AW         = DEF_IDX_BITS + DEF_TAG_BITS;

  typedef struct packed {
    logic                      valid;
    logic [DEF_AW-1:0]         addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wr_chan_t;

  typedef struct packed {
    logic                      valid;
    logic                      hit;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/rxbuf_port_arb.sv
// Same-index conflict resolver: among requesters targeting one entry index,
// only the lowest-numbered requester is granted.
module rxbuf_port_arb #(
  parameter int N        = 2,
  parameter int IDX_BITS = 3
) (
  input  logic [N-1:0]          req_i,
  input  logic [N*IDX_BITS-1:0] idx_i,
  output logic [N-1:0]          grant_o
);

  always_comb begin
    grant_o = req_i;
    for (int i = 1; i < N; i++) begin
      for (int j = 0; j < i; j++) begin
        if (req_i[j] && (idx_i[j*IDX_BITS +: IDX_BITS] == idx_i[i*IDX_BITS +: IDX_BITS])) begin
          grant_o[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/eu_rxbuf_mc.sv
// Multi-channel read-once receive buffer: direct-mapped entries written by the
// interconnect and consumed by ALU reads, with optional write-to-read forwarding.
module eu_rxbuf_mc
  import pkg_dtypes::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_BITS   = DEF_IDX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS,
  parameter int NUM_WR     = DEF_NUM_WR,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int BYPASS_EN  = DEF_BYPASS_EN
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    flush_i,
  input  logic [NUM_WR-1:0]                       wr_valid_i,
  input  logic [NUM_WR*(IDX_BITS+TAG_BITS)-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]            wr_data_i,
  output logic [NUM_WR-1:0]                       wr_ready_o,
  input  logic [NUM_RD-1:0]                       rd_valid_i,
  input  logic [NUM_RD*(IDX_BITS+TAG_BITS)-1:0]   rd_addr_i,
  output logic [NUM_RD-1:0]                       rd_valid_o,
  output logic [NUM_RD-1:0]                       rd_hit_o,
  output logic [NUM_RD*DATA_WIDTH-1:0]            rd_data_o,
  output logic [IDX_BITS:0]                       occupancy_o,
  output logic                                    full_o
);

  localparam int AW    = IDX_BITS + TAG_BITS;
  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [IDX_BITS:0] FULL_CNT = (IDX_BITS+1)'(DEPTH);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [DEPTH];
  logic [TAG_BITS-1:0]   tag_d  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [IDX_BITS:0]     occ_q, occ_d, occ_inc, occ_dec;

  logic [NUM_RD-1:0]            rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic [NUM_RD*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_WR*IDX_BITS-1:0]   wr_idx;
  logic [NUM_RD*IDX_BITS-1:0]   rd_idx;
  logic [NUM_WR-1:0]            wr_req, wr_grant, wr_bypassed;
  logic [NUM_RD-1:0]            rd_req, rd_grant, rd_byp;
  logic [NUM_RD*DATA_WIDTH-1:0] byp_data;
  logic [NUM_RD*NUM_WR-1:0]     byp_match;

  // Write handshake: wr_ready_o[c] is a same-cycle accept of wr_valid_i[c];
  // an unaccepted write is dropped and the requester must retry.
  always_comb begin
    wr_idx = '0;
    wr_req = '0;
    for (int c = 0; c < NUM_WR; c++) begin
      wr_idx[c*IDX_BITS +: IDX_BITS] = wr_addr_i[c*AW +: IDX_BITS];
      wr_req[c] = wr_valid_i[c] & ~flush_i & ~valid_q[wr_addr_i[c*AW +: IDX_BITS]];
    end
  end

  rxbuf_port_arb #(.N(NUM_WR), .IDX_BITS(IDX_BITS)) u_wr_arb (
    .req_i   (wr_req),
    .idx_i   (wr_idx),
    .grant_o (wr_grant)
  );

  // A read wants the entry if it is stored, or (bypass) if an accepted write targets the same full address.
  always_comb begin
    rd_idx    = '0;
    rd_req    = '0;
    rd_byp    = '0;
    byp_data  = '0;
    byp_match = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_idx[p*IDX_BITS +: IDX_BITS] = rd_addr_i[p*AW +: IDX_BITS];
      for (int c = 0; c < NUM_WR; c++) begin
        if ((BYPASS_EN != 0) && wr_grant[c] && (wr_addr_i[c*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
          byp_match[p*NUM_WR + c]          = 1'b1;
          rd_byp[p]                        = 1'b1;
          byp_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      rd_req[p] = rd_valid_i[p] & ~flush_i &
                  ((valid_q[rd_addr_i[p*AW +: IDX_BITS]] &
                    (tag_q[rd_addr_i[p*AW +: IDX_BITS]] == rd_addr_i[p*AW + IDX_BITS +: TAG_BITS])) |
                   rd_byp[p]);
    end
  end

  rxbuf_port_arb #(.N(NUM_RD), .IDX_BITS(IDX_BITS)) u_rd_arb (
    .req_i   (rd_req),
    .idx_i   (rd_idx),
    .grant_o (rd_grant)
  );

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    occ_inc     = '0;
    occ_dec     = '0;
    wr_bypassed = '0;
    rsp_valid_d = rd_valid_i;
    rsp_hit_d   = rd_grant;
    rsp_data_d  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_grant[p]) begin
        if (rd_byp[p]) begin
          rsp_data_d[p*DATA_WIDTH +: DATA_WIDTH] = byp_data[p*DATA_WIDTH +: DATA_WIDTH];
          wr_bypassed = wr_bypassed | byp_match[p*NUM_WR +: NUM_WR];
        end else begin
          rsp_data_d[p*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_addr_i[p*AW +: IDX_BITS]];
          valid_d[rd_addr_i[p*AW +: IDX_BITS]]   = 1'b0;
          occ_dec = occ_dec + 1'b1;
        end
      end
    end
    // A forwarded write was consumed in flight, so it never occupies the entry.
    for (int c = 0; c < NUM_WR; c++) begin
      if (wr_grant[c] && !wr_bypassed[c]) begin
        valid_d[wr_addr_i[c*AW +: IDX_BITS]] = 1'b1;
        tag_d[wr_addr_i[c*AW +: IDX_BITS]]   = wr_addr_i[c*AW + IDX_BITS +: TAG_BITS];
        data_d[wr_addr_i[c*AW +: IDX_BITS]]  = wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        occ_inc = occ_inc + 1'b1;
      end
    end
    occ_d = occ_q + occ_inc - occ_dec;
    if (flush_i) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      occ_q       <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign wr_ready_o  = wr_grant & {NUM_WR{reset_n}};
  assign rd_valid_o  = rsp_valid_q;
  assign rd_hit_o    = rsp_hit_q;
  assign rd_data_o   = rsp_data_q;
  assign occupancy_o = occ_q;
  assign full_o      = (occ_q == FULL_CNT);

endmodule

// File: tb/tb_eu_rxbuf_mc.sv
// Bench for eu_rxbuf_mc: two instances (forwarding on / off) share stimulus and
// are checked against an address-level buffer model.
module tb_eu_rxbuf_mc;

  localparam int DW = 16, IB = 2, TB = 2, NW = 2, NR = 2;
  localparam int AW = IB + TB, DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush_i;
  logic [NW-1:0]     wr_valid_i;
  logic [NW*AW-1:0]  wr_addr_i;
  logic [NW*DW-1:0]  wr_data_i;
  logic [NR-1:0]     rd_valid_i;
  logic [NR*AW-1:0]  rd_addr_i;

  // index 0: forwarding enabled, index 1: forwarding disabled
  logic [NW-1:0]    wr_ready  [2];
  logic [NR-1:0]    rd_valid_o[2];
  logic [NR-1:0]    rd_hit_o  [2];
  logic [NR*DW-1:0] rd_data_o [2];
  logic [IB:0]      occ_o     [2];
  logic             full_o    [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    eu_rxbuf_mc #(
      .DATA_WIDTH(DW), .IDX_BITS(IB), .TAG_BITS(TB),
      .NUM_WR(NW), .NUM_RD(NR), .BYPASS_EN(g == 0 ? 1 : 0)
    ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush_i),
      .wr_valid_i  (wr_valid_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .wr_ready_o  (wr_ready[g]),
      .rd_valid_i  (rd_valid_i),
      .rd_addr_i   (rd_addr_i),
      .rd_valid_o  (rd_valid_o[g]),
      .rd_hit_o    (rd_hit_o[g]),
      .rd_data_o   (rd_data_o[g]),
      .occupancy_o (occ_o[g]),
      .full_o      (full_o[g])
    );
  end

  // Model: each slot holds the full address and data of unread content.
  bit               mv [2][DEPTH];
  logic [AW-1:0]    ma [2][DEPTH];
  logic [DW-1:0]    md [2][DEPTH];
  logic [NW-1:0]    exp_rdy  [2];
  logic [NR-1:0]    exp_hit  [2];
  logic [NR*DW-1:0] exp_data [2];
  logic [NW-1:0]    rdy_seen [2];
  logic [NR-1:0]    exp_rv;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int waddr(input int c);
    return int'(wr_addr_i[c*AW +: AW]);
  endfunction

  function automatic int raddr(input int p);
    return int'(rd_addr_i[p*AW +: AW]);
  endfunction

  function automatic int model_count(input int m);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[m][i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++) mv[m][i] = 1'b0;
  endtask

  task automatic model_step(input int m);
    logic [NW-1:0]    rdy  = '0;
    logic [NW-1:0]    used = '0;
    logic [NR-1:0]    hit  = '0;
    logic [NR*DW-1:0] dat  = '0;
    bit claimed[DEPTH];
    bit clr[DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      claimed[i] = 1'b0;
      clr[i]     = 1'b0;
    end
    for (int c = 0; c < NW; c++) begin
      rdy[c] = wr_valid_i[c] && !flush_i && !mv[m][waddr(c) % DEPTH];
      for (int j = 0; j < c; j++)
        if (wr_valid_i[j] && (waddr(j) % DEPTH == waddr(c) % DEPTH)) rdy[c] = 1'b0;
    end
    for (int p = 0; p < NR; p++) begin
      int a  = raddr(p);
      int ix = a % DEPTH;
      if (rd_valid_i[p] && !flush_i && !claimed[ix]) begin
        if (mv[m][ix] && int'(ma[m][ix]) == a) begin
          hit[p] = 1'b1;
          dat[p*DW +: DW] = md[m][ix];
          claimed[ix] = 1'b1;
          clr[ix]     = 1'b1;
        end else if (m == 0) begin
          for (int c = 0; c < NW; c++) begin
            if (rdy[c] && !used[c] && waddr(c) == a) begin
              hit[p] = 1'b1;
              dat[p*DW +: DW] = wr_data_i[c*DW +: DW];
              used[c]     = 1'b1;
              claimed[ix] = 1'b1;
            end
          end
        end
      end
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) mv[m][i] = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (clr[i]) mv[m][i] = 1'b0;
      for (int c = 0; c < NW; c++) begin
        if (rdy[c] && !used[c]) begin
          mv[m][waddr(c) % DEPTH] = 1'b1;
          ma[m][waddr(c) % DEPTH] = AW'(waddr(c));
          md[m][waddr(c) % DEPTH] = wr_data_i[c*DW +: DW];
        end
      end
    end
    exp_rdy[m]  = rdy;
    exp_hit[m]  = hit;
    exp_data[m] = dat;
  endtask

  task automatic idle();
    flush_i    = 1'b0;
    wr_valid_i = '0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    rd_valid_i = '0;
    rd_addr_i  = '0;
  endtask

  task automatic wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid_i[c]         = 1'b1;
    wr_addr_i[c*AW +: AW] = a;
    wr_data_i[c*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_valid_i[p]         = 1'b1;
    rd_addr_i[p*AW +: AW] = a;
  endtask

  // Called at a falling edge with inputs driven; returns at the next falling edge with inputs idle.
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) begin
      model_step(m);
      rdy_seen[m] = wr_ready[m];
      chk($sformatf("wr_ready[%0d]", m), 32'(wr_ready[m]), 32'(exp_rdy[m]));
    end
    exp_rv = rd_valid_i;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rd_valid[%0d]", m), 32'(rd_valid_o[m]), 32'(exp_rv));
      chk($sformatf("rd_hit[%0d]", m),   32'(rd_hit_o[m]),   32'(exp_hit[m]));
      chk($sformatf("rd_data[%0d]", m),  rd_data_o[m],       exp_data[m]);
      chk($sformatf("occ[%0d]", m),      32'(occ_o[m]),      32'(model_count(m)));
      chk($sformatf("full[%0d]", m),     32'(full_o[m]),     32'(model_count(m) == DEPTH));
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    reset_n    = 1'b0;
    wr_valid_i = '1;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_wr_ready", 32'(wr_ready[m]),   32'h0);
      chk("rst_rd_valid", 32'(rd_valid_o[m]), 32'h0);
      chk("rst_rd_hit",   32'(rd_hit_o[m]),   32'h0);
      chk("rst_rd_data",  rd_data_o[m],       32'h0);
      chk("rst_occ",      32'(occ_o[m]),      32'h0);
      chk("rst_full",     32'(full_o[m]),     32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    // write then read-once consume
    wr(0, 4'h5, 16'hBEEF); cycle();
    chk("s1_occ_after_wr", 32'(occ_o[0]), 32'd1);
    rd(0, 4'h5); cycle();
    chk("s1_hit", 32'(rd_hit_o[0][0]), 32'd1);
    chk("s1_data", 32'(rd_data_o[0][15:0]), 32'hBEEF);
    chk("s1_occ_after_rd", 32'(occ_o[0]), 32'd0);
    rd(0, 4'h5); cycle();
    chk("s1_reread_miss", 32'(rd_hit_o[0][0]), 32'd0);

    // no overwrite of unread data, regardless of tag
    wr(0, 4'h1, 16'h1111); cycle();
    wr(1, 4'h5, 16'h2222); cycle();
    chk("s2_rdy_ch1", 32'(rdy_seen[0][1]), 32'd0);
    chk("s2_occ", 32'(occ_o[0]), 32'd1);
    rd(0, 4'h1); cycle();
    chk("s2_data", 32'(rd_data_o[0][15:0]), 32'h1111);

    // same-index write conflict, lowest channel wins
    wr(0, 4'h2, 16'hAAAA); wr(1, 4'h6, 16'hBBBB); cycle();
    chk("s3_rdy", 32'(rdy_seen[0]), 32'b01);
    rd(0, 4'h6); rd(1, 4'h2); cycle();
    chk("s3_hit", 32'(rd_hit_o[0]), 32'b10);
    chk("s3_data", 32'(rd_data_o[0][31:16]), 32'hAAAA);

    // fill, full rejection, drain
    wr(0, 4'h0, 16'h0A00); wr(1, 4'h1, 16'h0A01); cycle();
    wr(0, 4'h2, 16'h0A02); wr(1, 4'h3, 16'h0A03); cycle();
    chk("s4_full", 32'(full_o[0]), 32'd1);
    wr(0, 4'h4, 16'h0B04); wr(1, 4'h7, 16'h0B07); cycle();
    chk("s4_rdy_full", 32'(rdy_seen[0]), 32'b00);
    rd(0, 4'h0); cycle();
    chk("s4_not_full", 32'(full_o[0]), 32'd0);
    chk("s4_occ3", 32'(occ_o[0]), 32'd3);
    rd(0, 4'h1); rd(1, 4'h2); cycle();
    rd(0, 4'h3); cycle();

    // same-cycle write/read collision: forwarded vs committed
    wr(0, 4'h3, 16'h1234); rd(0, 4'h3); cycle();
    chk("s5_byp_hit", 32'(rd_hit_o[0][0]), 32'd1);
    chk("s5_byp_data", 32'(rd_data_o[0][15:0]), 32'h1234);
    chk("s5_byp_occ", 32'(occ_o[0]), 32'd0);
    chk("s5_nobyp_hit", 32'(rd_hit_o[1][0]), 32'd0);
    chk("s5_nobyp_occ", 32'(occ_o[1]), 32'd1);
    rd(0, 4'h3); cycle();
    chk("s5_nobyp_later", 32'(rd_data_o[1][15:0]), 32'h1234);

    // flush with concurrent traffic
    wr(0, 4'h0, 16'hC000); wr(1, 4'h1, 16'hC001); cycle();
    wr(0, 4'h2, 16'hC002); cycle();
    flush_i = 1'b1; wr(0, 4'h3, 16'hC003); rd(0, 4'h0); cycle();
    chk("s6_rdy", 32'(rdy_seen[0]), 32'b00);
    chk("s6_miss", 32'(rd_hit_o[0][0]), 32'd0);
    chk("s6_occ", 32'(occ_o[0]), 32'd0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NW; c++)
        if ($urandom_range(0, 9) < 6) wr(c, AW'($urandom_range(0, 15)), DW'($urandom));
      for (int p = 0; p < NR; p++)
        if ($urandom_range(0, 9) < 6) rd(p, AW'($urandom_range(0, 15)));
      flush_i = ($urandom_range(0, 39) == 0);
      cycle();
    end

    // asynchronous reset while a read response is held
    wr(0, 4'h1, 16'h5A5A); cycle();
    rd(0, 4'h1);
    @(posedge clk);
    #1;
    chk("s7_rv_before", 32'(rd_valid_o[0][0]), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    model_clear();
    for (int m = 0; m < 2; m++) begin
      chk("s7_rv_reset",  32'(rd_valid_o[m]), 32'h0);
      chk("s7_hit_reset", 32'(rd_hit_o[m]),   32'h0);
      chk("s7_occ_reset", 32'(occ_o[m]),      32'h0);
    end
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    rd(0, 4'h1); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/eu_rxbuf_mc.md
EU_RXBUF_MC -- requirements
Module: eu_rxbuf_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand data width in bits.
REQ-002 SHALL have parameter IDX_BITS, default 3: entry index width; depth = 2**IDX_BITS.
REQ-003 SHALL have parameter TAG_BITS, default 4: tag width; address width AW = IDX_BITS+TAG_BITS, index = addr[IDX_BITS-1:0].
REQ-004 SHALL have parameter NUM_WR, default 2: interconnect write channels.
REQ-005 SHALL have parameter NUM_RD, default 2: ALU read ports.
REQ-006 SHALL have parameter BYPASS_EN, default 1: enables same-cycle write-to-read forwarding.
REQ-007 clk  in  1  clock; single clock domain, all state on rising edge.
REQ-008 reset_n  in  1  reset, asynchronous, active-low.
REQ-009 flush_i  in  1  synchronous invalidate of all entries.
REQ-010 wr_valid_i  in  NUM_WR  per-channel write request.
REQ-011 wr_addr_i  in  NUM_WR*AW  per-channel write address.
REQ-012 wr_data_i  in  NUM_WR*DATA_WIDTH  per-channel write data.
REQ-013 wr_ready_o  out  NUM_WR  per-channel write accepted this cycle (combinational).
REQ-014 rd_valid_i  in  NUM_RD  per-port read request.
REQ-015 rd_addr_i  in  NUM_RD*AW  per-port read address.
REQ-016 rd_valid_o  out  NUM_RD  response strobe, one cycle after request.
REQ-017 rd_hit_o  out  NUM_RD  response hit flag.
REQ-018 rd_data_o  out  NUM_RD*DATA_WIDTH  response data; zero on miss.
REQ-019 occupancy_o  out  IDX_BITS+1  number of entries holding unread data.
REQ-020 full_o  out  1  occupancy_o == 2**IDX_BITS.

Function
REQ-021 Each entry SHALL hold valid bit, tag, data; an entry is valid from accepted write until consumed by a read hit or flush.
REQ-022 A write SHALL be accepted (wr_ready_o=1) iff wr_valid_i, flush_i=0, target entry invalid at cycle start, and no lower-numbered channel requests the same index this cycle.
REQ-023 A write to a valid entry SHALL be rejected regardless of tag; no overwrite of unread data.
REQ-024 A read SHALL hit iff rd_valid_i, flush_i=0, entry valid with matching tag, and no lower-numbered port hits the same index this cycle.
REQ-025 A read hit SHALL clear the entry valid bit at the next edge (read-once consume).
REQ-026 A read miss SHALL leave state unchanged; rd_valid_o=1, rd_hit_o=0, rd_data_o=0 next cycle.
REQ-027 With BYPASS_EN=1, a read to an invalid entry matched by an accepted write (same full address) in the same cycle SHALL hit with the write data, and the entry SHALL remain invalid.
REQ-028 With BYPASS_EN=0, the same collision SHALL be a read miss and the write SHALL commit normally.
REQ-029 Read latency SHALL be exactly one cycle; rd_valid_o SHALL equal rd_valid_i delayed one cycle.
REQ-030 occupancy_o SHALL update each edge by +(committed writes) -(consuming read hits), bypassed pairs contributing zero; it SHALL never wrap.
REQ-031 flush_i SHALL clear all valid bits and occupancy at the next edge; in that cycle all writes are rejected and all reads miss.

Reset
REQ-032 On reset_n=0 all valid bits, occupancy_o, full_o, rd_valid_o, rd_hit_o, rd_data_o SHALL go to 0 asynchronously; data/tag storage need not be reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries and any response pending in the output register.
REQ-034 wr_ready_o SHALL be 0 while reset_n=0.

Structure
REQ-035 Default parameter constants and the write-channel/read-response typedefs at default widths SHALL reside in pkg_dtypes.
REQ-036 A sub-module rxbuf_port_arb SHALL implement the lowest-index-wins same-index conflict resolution, instantiated once for writes and once for reads.
REQ-037 Storage SHALL be flip-flop arrays, NUM_WR write and NUM_RD read ports.

Verification (DATA_WIDTH=16, IDX_BITS=2, TAG_BITS=2, NUM_WR=2, NUM_RD=2)
REQ-038 Write ch0 addr 0x5 data 0xBEEF; next cycle read port0 0x5 -> following cycle hit=1 data 0xBEEF, occupancy 1->0; re-read 0x5 -> miss.
REQ-039 Entry 0x1 valid; write ch1 addr 0x5 (same index) -> wr_ready_o[1]=0, data unchanged, occupancy unchanged.
REQ-040 Both channels write index 2 same cycle (0x2, 0x6) -> only ch0 accepted; read 0x6 misses, 0x2 hits.
REQ-041 Fill 4 entries -> full_o=1, all writes rejected; one read hit -> full_o=0 next cycle, occupancy 3.
REQ-042 BYPASS_EN=1: write 0x3 data 0x1234 and read 0x3 same cycle -> hit data 0x1234, occupancy stays 0; BYPASS_EN=0 -> miss, occupancy 1.
REQ-043 Three entries valid, assert flush_i with concurrent write and read -> write rejected, read miss, occupancy 0; async reset mid-read -> rd_valid_o=0 immediately.
